// File: rtl/dsm_dac_mo.sv
// dsm_dac_mo: 1st/2nd-order delta-sigma bitstream DAC with a one-entry sample buffer.
// Define DSM_DITHER_EN to add a 16-bit LFSR dither bit to the first integrator input.
module dsm_dac_mo #(
  parameter int BW       = 16,
  parameter int OSR_LOG2 = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 mode_i,
  input  logic signed [BW-1:0] din_i,
  input  logic                 din_valid_i,
  output logic                 din_ready_o,
  output logic                 dac_o,
  output logic                 underrun_o,
  output logic                 ovf_o
);

  localparam int AW = BW + 4;
  localparam int EW = BW + 6;
  localparam logic [OSR_LOG2-1:0] CNT_MAX = '1;
  localparam logic [OSR_LOG2-1:0] CNT_ONE = {{(OSR_LOG2-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-BW-3){1'b0}}, {(BW+3){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-BW-3){1'b1}}, {(BW+2){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] FB_POS  = {{(EW-BW){1'b0}}, 1'b1, {(BW-1){1'b0}}};
  localparam logic signed [EW-1:0] FB_NEG  = {{(EW-BW+1){1'b1}}, {(BW-1){1'b0}}};

  function automatic logic signed [EW-1:0] ext(input logic signed [AW-1:0] a);
    ext = {{(EW-AW){a[AW-1]}}, a};
  endfunction

  function automatic logic signed [AW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[AW-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[AW-1:0];
    else                  sat = v[AW-1:0];
  endfunction

  function automatic logic clamps(input logic signed [EW-1:0] v);
    clamps = (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  logic [OSR_LOG2-1:0] cnt_q, cnt_d;
  logic signed [BW-1:0] pend_q, pend_d, act_q, act_d;
  logic                 pend_full_q, pend_full_d;
  logic                 mode_q, mode_d;
  logic signed [AW-1:0] i1_q, i1_d, i2_q, i2_d;
  logic                 dac_q, dac_d, und_q, und_d, ovf_q, ovf_d;

  logic                 accept, wrap;
  logic signed [EW-1:0] fb, dith, x_ext, sum1, sum2;
  logic signed [AW-1:0] i1_new, i2_new;

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    dith = {{(EW-1){1'b0}}, lfsr_q[0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign dith = '0;
`endif

  // Integrator arithmetic is carried at EW bits so the raw sums never wrap before clamping.
  always_comb begin
    accept = din_valid_i & ~pend_full_q;
    wrap   = en_i & (cnt_q == CNT_MAX);
    fb     = dac_q ? FB_POS : FB_NEG;
    x_ext  = {{(EW-BW){act_q[BW-1]}}, act_q} + dith;
    sum1   = ext(i1_q) + x_ext - fb;
    i1_new = sat(sum1);
    sum2   = ext(i2_q) + ext(i1_new) - fb;
    i2_new = sat(sum2);

    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;
    mode_d      = mode_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    dac_d       = dac_q;
    und_d       = 1'b0;
    ovf_d       = ovf_q;

    if (!en_i) begin
      cnt_d = '0;
      i1_d  = '0;
      i2_d  = '0;
      dac_d = ~dac_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      if (wrap && (mode_i != mode_q)) begin
        i1_d  = '0;
        i2_d  = '0;
        dac_d = 1'b1;
      end else if (!mode_q) begin
        i1_d  = i1_new;
        dac_d = ~i1_new[AW-1];
        ovf_d = ovf_q | clamps(sum1);
      end else begin
        i1_d  = i1_new;
        i2_d  = i2_new;
        dac_d = ~i2_new[AW-1];
        ovf_d = ovf_q | clamps(sum1) | clamps(sum2);
      end
    end

    // Period boundary: buffered sample first, then a same-cycle bypass, else underrun.
    if (wrap) begin
      mode_d = mode_i;
      if (pend_full_q) begin
        act_d       = pend_q;
        pend_full_d = 1'b0;
      end else if (accept) begin
        act_d = din_i;
      end else begin
        und_d = 1'b1;
      end
    end else if (accept) begin
      pend_d      = din_i;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      act_q       <= '0;
      mode_q      <= 1'b0;
      i1_q        <= '0;
      i2_q        <= '0;
      dac_q       <= 1'b0;
      und_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      act_q       <= act_d;
      mode_q      <= mode_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      dac_q       <= dac_d;
      und_q       <= und_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pend_q <= pend_d;
  end

  assign din_ready_o = ~pend_full_q;
  assign dac_o       = dac_q;
  assign underrun_o  = und_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/dsm_dac_mo.md
DSM_DAC_MO -- requirements
Module: dsm_dac_mo

Interface
REQ-001 SHALL have parameter BW, default 16: signed input sample width.
REQ-002 SHALL have parameter OSR_LOG2, default 6: log2 of the oversampling ratio, in cycles per sample period.
REQ-003 SHALL have clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have en_i, input, 1 bit: modulator enable.
REQ-006 SHALL have mode_i, input, 1 bit: 0 selects 1st order, 1 selects 2nd order.
REQ-007 SHALL have din_i, input, BW bits: signed two's-complement sample.
REQ-008 SHALL have din_valid_i, input, 1 bit, and din_ready_o, output, 1 bit: sample handshake.
REQ-009 SHALL have dac_o, output, 1 bit: registered bitstream.
REQ-010 SHALL have underrun_o, output, 1 bit: one-cycle pulse when no sample is available at a period boundary.
REQ-011 SHALL have ovf_o, output, 1 bit: sticky integrator-saturation flag.

Function
REQ-012 SHALL count cycles with a counter cnt running 0..2^OSR_LOG2-1 while en_i=1; "wrap" is the cycle with cnt at maximum.
REQ-013 SHALL accept a sample on a cycle with din_valid_i=1 and din_ready_o=1, storing it in a one-entry pending register.
REQ-014 SHALL drive din_ready_o as NOT pending_full, from registered state only, with no combinational path from din_valid_i.
REQ-015 SHALL, at wrap with pending_full=1, move pending to the active sample and clear pending_full.
REQ-016 SHALL, at wrap with pending empty and an accept in the same cycle, load the incoming sample directly into the active sample; pending stays empty and no underrun is flagged.
REQ-017 SHALL, at wrap with pending empty and no accept, hold the active sample and pulse underrun_o high for exactly one cycle.
REQ-018 SHALL compute feedback fb as +2^(BW-1) when dac_o=1 and -2^(BW-1) when dac_o=0, using the current dac_o register.
REQ-019 SHALL hold integrators i1 and i2, each signed BW+4 bits, with x the active sample sign-extended.
REQ-020 SHALL, in mode 0, update every enabled cycle as i1 <= sat(i1 + x - fb), and dac_o <= (new i1 >= 0).
REQ-021 SHALL, in mode 1, update every enabled cycle as i1 <= sat(i1 + x - fb), i2 <= sat(i2 + new i1 - fb), and dac_o <= (new i2 >= 0).
REQ-022 SHALL have sat() clamp to ±(2^(BW+3)-1), and SHALL set ovf_o on any clamp; ovf_o clears only on reset.
REQ-023 SHALL sample mode_i only at wrap; on a change of order, i1 and i2 SHALL be cleared in that same cycle.
REQ-024 SHALL, while en_i=0, hold cnt at 0, clear i1 and i2, keep accepting into pending, and toggle dac_o every cycle (zero-mean idle pattern).
REQ-025 SHALL restart the period with cnt=0 on the first cycle after en_i rises.

Reset
REQ-026 SHALL, on rst_i=1 at a clock edge, set cnt=0, i1=0, i2=0, pending_full=0, active sample=0, and registered mode=0.
REQ-027 SHALL, after reset, drive dac_o=0, din_ready_o=1, underrun_o=0 and ovf_o=0.
REQ-028 SHALL give rst_i priority over all other inputs; a reset asserted mid-period discards the pending and active samples.

Configuration
REQ-029 SHALL compile the dither feature only when macro DSM_DITHER_EN is defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1, reset to seed, advancing every enabled cycle) whose bit 0 is added as +1 LSB to x in the i1 update.
REQ-030 SHALL, without DSM_DITHER_EN, contain no LFSR and keep the port list identical to the dithered build.

Verification
REQ-031 SHALL cover reset: rst_i high 2 cycles -> dac_o=0, din_ready_o=1, underrun_o=0, ovf_o=0.
REQ-032 SHALL cover mode 0 with din=0x0000 held valid and BW=16, OSR_LOG2=6 -> ones count over 1024 cycles = 512±2, ovf_o=0.
REQ-033 SHALL cover mode 1 with din=0x4000 -> ones count over 4096 cycles = 3072±4, ovf_o=0.
REQ-034 SHALL cover the handshake: two back-to-back valid samples -> first accepted, din_ready_o=0 until the next wrap, second accepted in the cycle after that wrap.
REQ-035 SHALL cover underrun: din_valid_i=0 across a wrap -> underrun_o high exactly 1 cycle and active sample unchanged.
REQ-036 SHALL cover a mode switch: mode_i 0->1 mid-period -> order changes only at the next wrap, with i1=i2=0 in that cycle.
